input_arbiter: RTL and testbench

Front-end controller between the six raw player buttons and the game `control` block. It synchronises and debounces each button, turns presses into single command events, and generates auto-repeat for the four cursor buttons. It also accepts logic-analyser-injected events, then serialises everything into a one-command-at-a-time valid/ready stream. It sits in `top`, replacing the direct button wiring into `control`.

---
 rtl/asicle_pkg.sv | 51 +++++
 rtl/debouncer.sv | 44 ++++
 rtl/input_arbiter.sv | 123 ++++++++++++
 tb/tb_input_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/asicle_pkg.sv
// Shared command codes, button indices and the command priority order
// used by the input front end.
package asicle_pkg;

  localparam int unsigned NUM_BTN    = 6;
  localparam int unsigned NUM_CURSOR = 4;

  // Button index order matches inj_sel and the debug_out fields.
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_GUESS = 4;
  localparam int unsigned BTN_NEW   = 5;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;
  localparam logic [2:0] CMD_GUESS = 3'd5;
  localparam logic [2:0] CMD_NEW   = 3'd6;

  // Priority order: new > guess > up > down > left > right.
  function automatic logic [NUM_BTN-1:0] pick_first(input logic [NUM_BTN-1:0] pend);
    logic [NUM_BTN-1:0] pick;
    pick = '0;
    if (pend[BTN_NEW])        pick[BTN_NEW]   = 1'b1;
    else if (pend[BTN_GUESS]) pick[BTN_GUESS] = 1'b1;
    else if (pend[BTN_UP])    pick[BTN_UP]    = 1'b1;
    else if (pend[BTN_DOWN])  pick[BTN_DOWN]  = 1'b1;
    else if (pend[BTN_LEFT])  pick[BTN_LEFT]  = 1'b1;
    else if (pend[BTN_RIGHT]) pick[BTN_RIGHT] = 1'b1;
    return pick;
  endfunction

  function automatic logic [2:0] code_of(input logic [NUM_BTN-1:0] onehot);
    logic [2:0] code;
    case (onehot)
      6'b000001: code = CMD_UP;
      6'b000010: code = CMD_LEFT;
      6'b000100: code = CMD_RIGHT;
      6'b001000: code = CMD_DOWN;
      6'b010000: code = CMD_GUESS;
      6'b100000: code = CMD_NEW;
      default:   code = CMD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/debouncer.sv
// One button: two-flop synchroniser, debounce counter, stable state and a
// one-cycle press pulse registered on the same edge the stable state rises.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        stable <= sync_b;
        cnt    <= '0;
        press  <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Button front end: debounce, auto-repeat, injection, one-deep pending bits
// and a registered valid/ready command stage. Auto-repeat: INPUT_ARBITER_AUTOREPEAT_EN.
module input_arbiter
  import asicle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned REPEAT_DELAY    = 12000000,
  parameter int unsigned REPEAT_RATE     = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_guess,
  input  logic        btn_new,
  input  logic [5:0]  inj_sel,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [15:0] debug_out
);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_param_check
    $error("input_arbiter: timing parameters must be at least 1");
  end

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rep_evt;
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] pend_nxt;
  logic [NUM_BTN-1:0] consume;
  logic [NUM_BTN-1:0] drop_vec;
  logic [2:0]         drop_add;
  logic [4:0]         drop_sum;
  logic [3:0]         drop_cnt;
  logic [3:0]         drop_nxt;
  logic               load;
  logic               out_valid;
  logic [2:0]         out_code;

  assign btn_raw = {btn_new, btn_guess, btn_down, btn_right, btn_left, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .stable(stable[i]),
      .press (press[i])
    );
  end

`ifdef INPUT_ARBITER_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

  // Down-counter per cursor button; an event fires at terminal count while held.
  for (genvar i = 0; i < NUM_CURSOR; i++) begin : g_rep
    logic [TW-1:0] tmr;

    always_ff @(posedge clk) begin
      if (rst) begin
        tmr <= '0;
      end else if (press[i]) begin
        tmr <= DELAY_LOAD;
      end else if (!stable[i]) begin
        tmr <= '0;
      end else if (tmr == '0) begin
        tmr <= RATE_LOAD;
      end else begin
        tmr <= tmr - 1'b1;
      end
    end

    assign rep_evt[i] = stable[i] && !press[i] && (tmr == '0);
  end
  assign rep_evt[NUM_BTN-1:NUM_CURSOR] = '0;
`else
  assign rep_evt = '0;
`endif

  always_comb begin
    load     = !out_valid || cmd_ready;
    consume  = load ? pick_first(pend) : '0;
    evt      = press | rep_evt | inj_sel;
    // A bit consumed this cycle can take a new event without dropping it.
    drop_vec = evt & pend & ~consume;
    pend_nxt = (pend & ~consume) | evt;
    drop_add = 3'($countones(drop_vec));
    drop_sum = {1'b0, drop_cnt} + {2'b00, drop_add};
    drop_nxt = (drop_sum > 5'd15) ? 4'hf : drop_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      drop_cnt  <= '0;
      out_valid <= 1'b0;
      out_code  <= CMD_NONE;
    end else begin
      pend     <= pend_nxt;
      drop_cnt <= drop_nxt;
      if (load) begin
        out_valid <= |pend;
        out_code  <= code_of(consume);
      end
    end
  end

  assign cmd_valid = out_valid;
  assign cmd_code  = out_code;
  assign debug_out = {drop_cnt, pend, stable};

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter with short debounce/repeat timings;
// expectations follow INPUT_ARBITER_AUTOREPEAT_EN when it is defined.
module tb_input_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_down = 1'b0, btn_guess = 1'b0, btn_new = 1'b0;
  logic [5:0]  inj_sel = '0;
  logic        cmd_ready = 1'b1;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] debug_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INPUT_ARBITER_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  input_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_down (btn_down),
    .btn_guess(btn_guess),
    .btn_new  (btn_new),
    .inj_sel  (inj_sel),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .debug_out(debug_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after "edge 0", the last edge with rst high.
  task automatic do_reset();
    rst       = 1'b1;
    btn_up    = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_down  = 1'b0; btn_guess = 1'b0; btn_new = 1'b0;
    inj_sel   = '0;
    cmd_ready = 1'b1;
    next_edge();
    next_edge();
    rst = 1'b0;
  endtask

  function automatic bit right_expected(input int n);
    if (n == 8) return 1'b1;
    if (AUTOREP && (n == 28 || n == 36 || n == 44 || n == 52 || n == 60)) return 1'b1;
    return 1'b0;
  endfunction

  logic [2:0] arb_codes [6];

  initial begin
    arb_codes = '{3'd6, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};

    // Reset state
    do_reset();
    chk("rst_valid", 16'(cmd_valid), 16'd0);
    chk("rst_code",  16'(cmd_code),  16'd0);
    chk("rst_debug", debug_out,      16'h0000);

    // Glitch shorter than the debounce window
    do_reset();
    btn_up = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      next_edge();
      if (n == 3) btn_up = 1'b0;
      chk("glitch_valid",  16'(cmd_valid),    16'd0);
      chk("glitch_stable", 16'(debug_out[0]), 16'd0);
    end

    // Clean press of left: one command at edge 8
    do_reset();
    btn_left = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      next_edge();
      chk("left_valid", 16'(cmd_valid), (n == 8) ? 16'd1 : 16'd0);
      chk("left_code",  16'(cmd_code),  (n == 8) ? 16'd2 : 16'd0);
      if (n == 6) chk("left_stable", 16'(debug_out[1]), 16'd1);
      if (n == 7) chk("left_pend",   16'(debug_out[7]), 16'd1);
    end

    // Held right: press at 8, repeats every 8 from 28 when enabled
    do_reset();
    btn_right = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      next_edge();
      if (n == 60) btn_right = 1'b0;
      chk("right_valid", 16'(cmd_valid), right_expected(n) ? 16'd1 : 16'd0);
      chk("right_code",  16'(cmd_code),  right_expected(n) ? 16'd3 : 16'd0);
    end

    // All six injected together: priority order on edges 2..7
    do_reset();
    inj_sel = 6'b111111;
    for (int n = 1; n <= 9; n++) begin
      next_edge();
      if (n == 1) begin
        inj_sel = '0;
        chk("arb_pend_all", 16'(debug_out[11:6]), 16'h3f);
      end
      chk("arb_valid", 16'(cmd_valid), (n >= 2 && n <= 7) ? 16'd1 : 16'd0);
      chk("arb_code",  16'(cmd_code),  (n >= 2 && n <= 7) ? 16'(arb_codes[n-2]) : 16'd0);
    end

    // Backpressure: held, pending, dropped
    do_reset();
    cmd_ready = 1'b0;
    inj_sel   = 6'b000001;
    for (int n = 1; n <= 9; n++) begin
      next_edge();
      inj_sel = (n == 3 || n == 5) ? 6'b000001 : 6'b000000;
      if (n >= 2 && n <= 7) begin
        chk("bp_held_valid", 16'(cmd_valid), 16'd1);
        chk("bp_held_code",  16'(cmd_code),  16'd1);
      end
      if (n == 7) begin
        chk("bp_pend_up", 16'(debug_out[6]),     16'd1);
        chk("bp_drop",    16'(debug_out[15:12]), 16'd1);
        cmd_ready = 1'b1;
      end
      if (n == 8) begin
        chk("bp_second_valid", 16'(cmd_valid),    16'd1);
        chk("bp_second_code",  16'(cmd_code),     16'd1);
        chk("bp_pend_clear",   16'(debug_out[6]), 16'd0);
      end
      if (n == 9) begin
        chk("bp_drained",     16'(cmd_valid),        16'd0);
        chk("bp_drop_kept",   16'(debug_out[15:12]), 16'd1);
      end
    end

    // Reset while guess is held unaccepted
    do_reset();
    cmd_ready = 1'b0;
    inj_sel   = 6'b010000;
    next_edge();
    inj_sel = '0;
    next_edge();
    chk("rh_held_valid", 16'(cmd_valid), 16'd1);
    chk("rh_held_code",  16'(cmd_code),  16'd5);
    next_edge();
    rst = 1'b1;
    next_edge();
    rst       = 1'b0;
    cmd_ready = 1'b1;
    chk("rh_valid", 16'(cmd_valid), 16'd0);
    chk("rh_code",  16'(cmd_code),  16'd0);
    chk("rh_debug", debug_out,      16'h0000);
    next_edge();
    chk("rh_after_valid", 16'(cmd_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
